// File: rtl/i2c_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : i2c_pkg                                                      |
// | Description : Shared types and constants for the FIFO-fed I2C write        |
// |               master: controller state encoding, SCL quarter-phase         |
// |               encoding and the R/W bit value for a write.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package i2c_pkg;

   // Controller states. POP is the only state with no bus timing (SCL held low).
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_ADDR     = 3'd2,
      ST_ADDR_ACK = 3'd3,
      ST_POP      = 3'd4,
      ST_DATA     = 3'd5,
      ST_DATA_ACK = 3'd6,
      ST_STOP     = 3'd7
   } state_t;

   // Quarter-period phase within one SCL bit slot.
   localparam logic [1:0] PH_Q0 = 2'd0;
   localparam logic [1:0] PH_Q1 = 2'd1;
   localparam logic [1:0] PH_Q2 = 2'd2;
   localparam logic [1:0] PH_Q3 = 2'd3;

   // R/W bit appended to the 7-bit address; this master only writes.
   localparam logic I2C_WRITE = 1'b0;

endpackage : i2c_pkg
`default_nettype wire

// File: rtl/i2c_phase_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_phase_gen                                                |
// | Description : Quarter-period tick generator for SCL timing. While en is   |
// |               high a tick is produced on the last clock of every CLK_DIV  |
// |               clock quarter, and phase steps q0..q3. While en is low the  |
// |               divider and phase hold at zero so every enable starts a     |
// |               fresh, full-length q0.                                       |
// | Ports       : clk   - clock                                                |
// |               rst   - synchronous active-high reset                        |
// |               en    - run the divider                                      |
// |               tick  - last cycle of the current quarter                    |
// |               phase - current quarter (q0..q3)                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_phase_gen
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       tick,
   output logic [1:0] phase
);

   localparam int unsigned      CNT_W    = 10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       phase_q, phase_d;
   logic             tick_w;

   always_comb begin
      tick_w  = en && (cnt_q == CNT_LAST);
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!en) begin
         cnt_d   = '0;
         phase_d = PH_Q0;
      end else if (tick_w) begin
         cnt_d   = '0;
         phase_d = phase_q + 2'd1;
      end else begin
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= PH_Q0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign tick  = tick_w;
   assign phase = phase_q;

endmodule : i2c_phase_gen
`default_nettype wire

// File: rtl/i2c_fifo_master_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2c_fifo_master_tx                                           |
// | Description : I2C write master that drains a FIFO. When the FIFO becomes  |
// |               non-empty it issues START, the target address with W=0,     |
// |               then pops and sends bytes while the target ACKs and the     |
// |               FIFO has data, and ends with STOP. A NACK ends the          |
// |               transfer and latches nack_err, which blocks new transfers   |
// |               until reset.                                                 |
// | Ports       : rd_clk   - clock            rd_rst   - sync reset, act-high |
// |               rd_data  - FIFO data (valid the cycle after rd_en)          |
// |               rd_empty - FIFO empty        rd_en    - FIFO pop strobe      |
// |               scl_o    - SCL (1 = release) sda_o    - SDA (1 = release)    |
// |               sda_i    - SDA line sample (asynchronous)                   |
// |               busy     - transfer active  done     - STOP complete pulse  |
// |               nack_err - sticky NACK flag                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module i2c_fifo_master_tx
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV  = 4,
   parameter logic [6:0]  TGT_ADDR = 7'h50
) (
   input  logic       rd_clk,
   input  logic       rd_rst,
   input  logic [7:0] rd_data,
   input  logic       rd_empty,
   output logic       rd_en,
   output logic       scl_o,
   output logic       sda_o,
   input  logic       sda_i,
   output logic       busy,
   output logic       done,
   output logic       nack_err
);

   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       pop_first_q, pop_first_d;
   logic       nack_seen_q, nack_seen_d;
   logic       nack_err_q, nack_err_d;
   logic       done_q, done_d;
   logic       scl_q, scl_d;
   logic       sda_q, sda_d;
   logic       sda_s1_q, sda_s2_q;

   logic       ph_en;
   logic       tick;
   logic [1:0] phase;
   logic       q2_end, q3_end;

   // POP has no bus timing; holding the divider there makes DATA start on a full q0.
   assign ph_en = (state_q != ST_IDLE) && (state_q != ST_POP);

   i2c_phase_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_phase_gen (
      .clk   (rd_clk),
      .rst   (rd_rst),
      .en    (ph_en),
      .tick  (tick),
      .phase (phase)
   );

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      pop_first_d = pop_first_q;
      nack_seen_d = nack_seen_q;
      nack_err_d  = nack_err_q;
      done_d      = 1'b0;
      rd_en       = 1'b0;
      scl_d       = 1'b1;
      sda_d       = 1'b1;
      q2_end      = tick && (phase == PH_Q2);
      q3_end      = tick && (phase == PH_Q3);

      unique case (state_q)
         ST_IDLE: begin
            if (!rd_empty && !nack_err_q) begin
               state_d    = ST_START;
               shift_d    = {TGT_ADDR, I2C_WRITE};
               bit_cnt_d  = 3'd7;
               nack_err_d = 1'b0;
            end
         end

         ST_START: begin
            unique case (phase)
               PH_Q0:   begin scl_d = 1'b1; sda_d = 1'b1; end
               PH_Q1:   begin scl_d = 1'b1; sda_d = 1'b0; end
               PH_Q2:   begin scl_d = 1'b1; sda_d = 1'b0; end
               default: begin scl_d = 1'b0; sda_d = 1'b0; end
            endcase
            if (q3_end) state_d = ST_ADDR;
         end

         ST_ADDR, ST_DATA: begin
            // Shift register only moves at the q3->q0 boundary, so SDA changes in q0 only.
            scl_d = phase[1];
            sda_d = shift_q[7];
            if (q3_end) begin
               if (bit_cnt_q == 3'd0) begin
                  state_d = (state_q == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
               end else begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - 3'd1;
               end
            end
         end

         ST_ADDR_ACK, ST_DATA_ACK: begin
            scl_d = phase[1];
            sda_d = 1'b1;
            if (q2_end) nack_seen_d = sda_s2_q;
            if (q3_end) begin
               if (nack_seen_q) begin
                  nack_err_d = 1'b1;
                  state_d    = ST_STOP;
               end else if (!rd_empty) begin
                  pop_first_d = 1'b1;
                  state_d     = ST_POP;
               end else begin
                  state_d = ST_STOP;
               end
            end
         end

         ST_POP: begin
            // Cycle 1 pops, cycle 2 captures the read data.
            scl_d = 1'b0;
            sda_d = 1'b1;
            if (pop_first_q) begin
               pop_first_d = 1'b0;
               if (rd_empty) begin
                  state_d = ST_STOP;
               end else begin
                  rd_en = 1'b1;
               end
            end else begin
               shift_d   = rd_data;
               bit_cnt_d = 3'd7;
               state_d   = ST_DATA;
            end
         end

         ST_STOP: begin
            unique case (phase)
               PH_Q0:   begin scl_d = 1'b0; sda_d = 1'b0; end
               PH_Q1:   begin scl_d = 1'b1; sda_d = 1'b0; end
               PH_Q2:   begin scl_d = 1'b1; sda_d = 1'b1; end
               default: begin scl_d = 1'b1; sda_d = 1'b1; end
            endcase
            if (q3_end) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         pop_first_q <= 1'b0;
         nack_seen_q <= 1'b0;
         nack_err_q  <= 1'b0;
         done_q      <= 1'b0;
         scl_q       <= 1'b1;
         sda_q       <= 1'b1;
         sda_s1_q    <= 1'b1;
         sda_s2_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         pop_first_q <= pop_first_d;
         nack_seen_q <= nack_seen_d;
         nack_err_q  <= nack_err_d;
         done_q      <= done_d;
         scl_q       <= scl_d;
         sda_q       <= sda_d;
         sda_s1_q    <= sda_i;
         sda_s2_q    <= sda_s1_q;
      end
   end

   assign scl_o    = scl_q;
   assign sda_o    = sda_q;
   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign nack_err = nack_err_q;

endmodule : i2c_fifo_master_tx
`default_nettype wire

// File: tb/tb_i2c_fifo_master_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_i2c_fifo_master_tx                                        |
// | Description : Directed bench for i2c_fifo_master_tx with a FIFO model, an  |
// |               ACK/NACK target model and an open-drain bus monitor that    |
// |               decodes START/STOP, bytes and ACK bits.                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_i2c_fifo_master_tx;

   localparam int unsigned CLK_DIV  = 4;
   localparam logic [6:0]  TGT_ADDR = 7'h50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] rd_data;
   logic       rd_empty;
   logic       rd_en;
   logic       scl_o, sda_o, sda_i;
   logic       busy, done, nack_err;

   always #5 clk = ~clk;

   i2c_fifo_master_tx #(
      .CLK_DIV  (CLK_DIV),
      .TGT_ADDR (TGT_ADDR)
   ) dut (
      .rd_clk   (clk),
      .rd_rst   (rst),
      .rd_data  (rd_data),
      .rd_empty (rd_empty),
      .rd_en    (rd_en),
      .scl_o    (scl_o),
      .sda_o    (sda_o),
      .sda_i    (sda_i),
      .busy     (busy),
      .done     (done),
      .nack_err (nack_err)
   );

   // FIFO model: data appears on rd_data the cycle after rd_en.
   logic [7:0] fifo_mem [0:31];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   logic       flush  = 1'b0;

   assign rd_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (flush) begin
         rd_ptr <= wr_ptr;
      end else if (rd_en) begin
         rd_data <= fifo_mem[rd_ptr[4:0]];
         rd_ptr  <= rd_ptr + 1;
      end
   end

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr[4:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   // Open-drain bus, target model and monitor.
   logic       sda_drv   = 1'b1;
   logic       nack_addr = 1'b0;
   assign sda_i = sda_o & sda_drv;

   int         cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         start_cnt = 0, stop_cnt = 0, done_cnt = 0, rden_cnt = 0, viol_cnt = 0;
   int         nbytes = 0, nacks = 0, bitn = 0, frame = 0;
   int         last_rise = 0, addr_period = 0;
   logic [7:0] rx_bytes [0:15];
   logic       rx_acks  [0:15];
   logic [7:0] sh = 8'h00;
   logic       prev_scl = 1'b1, prev_sda = 1'b1;

   always @(negedge clk) begin
      logic line;
      line = sda_o & sda_drv;
      if (done) done_cnt++;
      if (rd_en) rden_cnt++;
      if (rd_en && rd_empty) viol_cnt++;
      if (rst) begin
         sda_drv = 1'b1;
         bitn    = 0;
      end else begin
         // Any SDA edge while SCL stays high is a START or STOP; stray ones show up in the counts.
         if (prev_scl && scl_o && prev_sda && !line) begin
            start_cnt++;
            bitn  = 0;
            frame = 0;
         end else if (prev_scl && scl_o && !prev_sda && line) begin
            stop_cnt++;
         end
         if (!prev_scl && scl_o) begin
            bitn++;
            if (bitn <= 8) sh = {sh[6:0], line};
            if (bitn == 8 && nbytes < 16) begin
               rx_bytes[nbytes] = sh;
               nbytes++;
            end
            if (bitn == 2 && frame == 0) addr_period = cyc - last_rise;
            if (bitn == 9) begin
               if (nacks < 16) rx_acks[nacks] = line;
               nacks++;
               bitn = 0;
               frame++;
            end
            last_rise = cyc;
         end
         if (prev_scl && !scl_o) begin
            if (bitn == 8 && !(nack_addr && frame == 0)) sda_drv = 1'b0;
            else if (bitn == 0) sda_drv = 1'b1;
         end
      end
      prev_scl = scl_o;
      prev_sda = line;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      start_cnt = 0; stop_cnt = 0; done_cnt = 0; rden_cnt = 0;
      nbytes = 0; nacks = 0; bitn = 0; frame = 0;
   endtask

   task automatic wait_done(input int n, input string tag);
      int k;
      k = 0;
      while (done_cnt < n && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(done_cnt >= n), 32'd1);
   endtask

   initial begin
      int k;
      int r0;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_scl", scl_o, 1);
      chk("rst_sda", sda_o, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_nack", nack_err, 0);
      chk("rst_rden", rd_en, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      clear_mon();

      // Single byte 0x3C, target ACKs
      push(8'h3C);
      wait_done(1, "s1_done_seen");
      repeat (5) @(negedge clk);
      chk("s1_start", start_cnt, 1);
      chk("s1_stop", stop_cnt, 1);
      chk("s1_rden", rden_cnt, 1);
      chk("s1_done_cnt", done_cnt, 1);
      chk("s1_nbytes", nbytes, 2);
      chk("s1_addr", rx_bytes[0], 8'hA0);
      chk("s1_data", rx_bytes[1], 8'h3C);
      chk("s1_ack0", rx_acks[0], 0);
      chk("s1_ack1", rx_acks[1], 0);
      chk("s1_scl_period", addr_period, 16);
      chk("s1_nack", nack_err, 0);
      chk("s1_busy", busy, 0);
      clear_mon();

      // Three bytes in one transaction
      push(8'h01); push(8'hFF); push(8'h80);
      wait_done(1, "s2_done_seen");
      repeat (5) @(negedge clk);
      chk("s2_start", start_cnt, 1);
      chk("s2_stop", stop_cnt, 1);
      chk("s2_rden", rden_cnt, 3);
      chk("s2_nbytes", nbytes, 4);
      chk("s2_b1", rx_bytes[1], 8'h01);
      chk("s2_b2", rx_bytes[2], 8'hFF);
      chk("s2_b3", rx_bytes[3], 8'h80);
      chk("s2_nacks", nacks, 4);
      clear_mon();

      // Address NACK
      nack_addr = 1'b1;
      push(8'h55);
      wait_done(1, "s3_done_seen");
      repeat (5) @(negedge clk);
      chk("s3_nack", nack_err, 1);
      chk("s3_ack0", rx_acks[0], 1);
      chk("s3_rden", rden_cnt, 0);
      chk("s3_stop", stop_cnt, 1);
      repeat (200) @(negedge clk);
      chk("s3_no_retry", start_cnt, 1);
      chk("s3_idle", busy, 0);
      chk("s3_rden_hold", rden_cnt, 0);
      flush = 1'b1;
      rst   = 1'b1;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      flush     = 1'b0;
      nack_addr = 1'b0;
      @(negedge clk);
      chk("s3_nack_clr", nack_err, 0);
      repeat (3) @(negedge clk);
      clear_mon();

      // FIFO empties after first data ACK; new byte pushed during STOP
      push(8'hAA);
      k = 0;
      while (nacks < 2 && k < 2000) begin @(negedge clk); k++; end
      chk("s4_ack_seen", 32'(nacks >= 2), 1);
      k = 0;
      while (scl_o !== 1'b0 && k < 200) begin @(negedge clk); k++; end
      chk("s4_stop_q0", scl_o, 0);
      push(8'h5B);
      wait_done(2, "s4_done_seen");
      repeat (5) @(negedge clk);
      chk("s4_start", start_cnt, 2);
      chk("s4_stop", stop_cnt, 2);
      chk("s4_rden", rden_cnt, 2);
      chk("s4_nbytes", nbytes, 4);
      chk("s4_b1", rx_bytes[1], 8'hAA);
      chk("s4_b2", rx_bytes[2], 8'hA0);
      chk("s4_b3", rx_bytes[3], 8'h5B);
      clear_mon();

      // Reset during the 4th data bit
      push(8'hC3);
      k = 0;
      while (!(frame == 1 && bitn == 4) && k < 2000) begin @(negedge clk); k++; end
      chk("s5_bit4", 32'(frame == 1 && bitn == 4), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("s5_scl", scl_o, 1);
      chk("s5_sda", sda_o, 1);
      chk("s5_busy", busy, 0);
      rst = 1'b0;
      r0  = rden_cnt;
      repeat (100) @(negedge clk);
      chk("s5_rden_hold", rden_cnt, r0);
      chk("s5_idle", busy, 0);
      push(8'h7E);
      wait_done(1, "s5_done_seen");
      repeat (5) @(negedge clk);
      chk("s5_nbytes", nbytes, 3);
      chk("s5_new_byte", rx_bytes[2], 8'h7E);
      chk("s5_rden_tot", rden_cnt, 2);

      chk("rden_while_empty", viol_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_i2c_fifo_master_tx
`default_nettype wire

// File: doc/i2c_fifo_master_tx.md
I2C_FIFO_MASTER_TX -- requirements
Module: i2c_fifo_master_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: rd_clk cycles per SCL quarter-period; legal range 2..1023.
REQ-002 SHALL have parameter TGT_ADDR, default 7'h50: 7-bit target address sent with a write bit (0).
REQ-003 rd_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 rd_rst  input  1  synchronous, active-high reset.
REQ-005 rd_data  input  8  FIFO read data, valid the cycle after rd_en.
REQ-006 rd_empty  input  1  FIFO empty flag.
REQ-007 rd_en  output  1  FIFO pop strobe, one cycle per byte.
REQ-008 scl_o  output  1  SCL drive; 1 = release (high), 0 = pull low.
REQ-009 sda_o  output  1  SDA drive; 1 = release, 0 = pull low.
REQ-010 sda_i  input  1  sampled SDA line; used for ACK detection, synchronized internally with 2 flops.
REQ-011 busy  output  1  high from START through end of STOP.
REQ-012 done  output  1  one-cycle pulse when STOP completes.
REQ-013 nack_err  output  1  sticky NACK flag; cleared at the next START or at reset.

Function
REQ-014 SHALL advance bus timing only on a quarter tick, asserted every CLK_DIV cycles while busy; the counter SHALL hold at 0 in IDLE.
REQ-015 States SHALL be IDLE, START, ADDR, ADDR_ACK, POP, DATA, DATA_ACK, STOP.
REQ-016 IDLE -> START when rd_empty=0; scl_o=sda_o=1 in IDLE.
REQ-017 START: q0 both high; q1 sda_o=0; q2 sda_o=0; q3 scl_o=0; then ADDR.
REQ-018 Each bit SHALL take 4 quarters, MSB first: q0 scl_o=0 and drive sda_o; q1 scl_o=0; q2 scl_o=1; q3 scl_o=1. sda_o SHALL change only in q0.
REQ-019 ADDR SHALL send {TGT_ADDR,1'b0}; ADDR_ACK and DATA_ACK SHALL release sda_o and sample synchronized sda_i at the end of q2 (0 = ACK).
REQ-020 On ACK: ADDR_ACK/DATA_ACK -> POP if rd_empty=0, else -> STOP.
REQ-021 POP: rd_en=1 for exactly one cycle, only when rd_empty=0; load rd_data into the shift register on the following cycle; -> DATA. SCL SHALL stay low throughout POP.
REQ-022 rd_en SHALL never be asserted while rd_empty=1 or outside POP.
REQ-023 On NACK: set nack_err; -> STOP; no further pops in this transaction.
REQ-024 STOP: q0 scl_o=0, sda_o=0; q1 scl_o=1; q2 sda_o=1; q3 hold; then pulse done and go to IDLE.
REQ-025 After a NACK, SHALL NOT restart while nack_err=1 and rd_empty=0, until reset.
REQ-026 Clock stretching and arbitration SHALL NOT be supported; scl_o is not read back.
REQ-027 Bytes SHALL be transmitted in exact FIFO order with no duplication or loss.

Reset
REQ-028 On rd_rst: state=IDLE, scl_o=1, sda_o=1, rd_en=0, busy=0, done=0, nack_err=0, counters and shift register cleared.
REQ-029 Reset mid-transfer SHALL release both lines in the next cycle; no STOP is generated.

Structure
REQ-030 Shared package i2c_pkg SHALL hold the state enum, phase encoding q0..q3, and the I2C write-bit constant.
REQ-031 The quarter-tick divider SHALL be a sub-module i2c_phase_gen (inputs: clk, rst, en; outputs: tick, phase[1:0]).

Verification
REQ-032 CLK_DIV=4, TGT_ADDR=7'h50, FIFO holds 0x3C, target ACKs all -> SDA bits 0xA0, ACK, 0x3C, ACK, STOP; exactly one rd_en; done pulse; SCL period 16 cycles.
REQ-033 FIFO holds 0x01,0xFF,0x80 -> three rd_en pulses, bytes sent in order, single START and single STOP.
REQ-034 Target NACKs the address -> nack_err=1, STOP issued, zero rd_en, no retry while the FIFO is non-empty.
REQ-035 FIFO empties after the first data ACK, then a byte is pushed mid-STOP -> current transaction ends; the new byte goes out in a new START.
REQ-036 Assert rd_rst during the 4th data bit -> next cycle scl_o=sda_o=1, busy=0; no rd_en until rd_empty=0 again.
REQ-037 Throughout all scenarios, a checker SHALL flag rd_en while rd_empty=1, and any sda_o change while scl_o=1 outside START/STOP.
